uk101_text_capture: RTL and testbench

Capture buffer for the text path out of the machine. Bytes the UK101 ACIA transmits (SAVE/LIST output) are stored in an on-chip RAM. The HPS then reads them back as a TXT file through the ioctl upload handshake. This is the reverse of the "Load Ascii" download path: the download writes text into the machine, and this block reads text out of it.

---
 rtl/uk101_text_capture_pkg.sv | 21 ++
 rtl/uk101_text_capture_ram.sv | 26 ++
 rtl/uk101_text_capture.sv | 115 +++++++++++
 tb/tb_uk101_text_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uk101_text_capture_pkg.sv
// uk101_cap_pkg: shared types and helpers for the UK101 text capture buffer.
`default_nettype none

package uk101_cap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RD    = 2'd2,
    RESP  = 2'd3
  } cap_state_e;

  localparam logic [7:0] NUL = 8'h00;

  function automatic logic [7:0] mask_byte(input logic [7:0] b, input logic mask_b7);
    return mask_b7 ? {1'b0, b[6:0]} : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uk101_text_capture_ram.sv
// uk101_cap_ram: inferred simple-dual-port byte RAM with a registered read port.
`default_nettype none

module uk101_cap_ram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

`default_nettype wire

// File: rtl/uk101_text_capture.sv
// uk101_text_capture: stores bytes written to the ACIA transmit register and
// returns them to the HPS through the ioctl upload handshake.
`default_nettype none

module uk101_text_capture
  import uk101_cap_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter bit MASK_B7  = 1'b1,
  parameter bit DROP_NUL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            capture_en,
  input  logic            capture_clear,
  input  logic [7:0]      tx_data,
  input  logic            tx_strobe,
  input  logic            ioctl_upload,
  input  logic            ioctl_rd,
  input  logic [15:0]     ioctl_addr,
  output logic [7:0]      ioctl_din,
  output logic            ioctl_wait,
  output logic [ADDR_W:0] capture_len,
  output logic            capturing,
  output logic            overflow
);

  cap_state_e        state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   capture_len_q;
  logic              overflow_q;
  logic [7:0]        ioctl_din_q;
  logic              ioctl_wait_q;
  logic [15:0]       rd_addr_q;
  logic [7:0]        ram_rdata;

  logic [7:0] tx_byte;
  logic       byte_kept;
  logic       buf_full;
  logic       store;
  logic       lost;
  logic       rd_req;
  logic       in_range;

  assign tx_byte   = mask_byte(tx_data, MASK_B7);
  // Clear outranks a coincident store, so a kept byte never survives a clear.
  assign byte_kept = (state_q == ARMED) && !ioctl_upload && tx_strobe && !capture_clear
                     && !(DROP_NUL && (tx_byte == NUL));
  assign buf_full  = capture_len_q[ADDR_W];
  assign store     = byte_kept && !buf_full;
  assign lost      = byte_kept && buf_full;
  assign rd_req    = ioctl_rd && ioctl_upload && (state_q != RD) && (state_q != RESP);
  // Full 16-bit compare so addresses beyond the buffer depth read as NUL.
  assign in_range  = {1'b0, rd_addr_q} < 17'(capture_len_q);

  uk101_cap_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i (tx_byte),
    .raddr_i (rd_addr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      capture_len_q <= '0;
      overflow_q    <= 1'b0;
      ioctl_din_q   <= NUL;
      ioctl_wait_q  <= 1'b0;
      rd_addr_q     <= '0;
    end else begin
      if (rd_req) begin
        state_q      <= RD;
        rd_addr_q    <= ioctl_addr;
        ioctl_wait_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE:    if (capture_en && !ioctl_upload) state_q <= ARMED;
          ARMED:   if (!capture_en) state_q <= IDLE;
          RD:      state_q <= RESP;
          RESP: begin
            ioctl_din_q  <= in_range ? ram_rdata : NUL;
            ioctl_wait_q <= 1'b0;
            state_q      <= (capture_en && !ioctl_upload) ? ARMED : IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end

      // wr_ptr only rolls to zero on the write that fills the buffer; writes stop there.
      if (capture_clear) begin
        wr_ptr_q      <= '0;
        capture_len_q <= '0;
        overflow_q    <= 1'b0;
      end else if (store) begin
        wr_ptr_q      <= wr_ptr_q + 1'b1;
        capture_len_q <= capture_len_q + 1'b1;
      end else if (lost) begin
        overflow_q    <= 1'b1;
      end
    end
  end

  assign ioctl_din   = ioctl_din_q;
  assign ioctl_wait  = ioctl_wait_q;
  assign capture_len = capture_len_q;
  assign capturing   = (state_q == ARMED);
  assign overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uk101_text_capture.sv
// Bench for uk101_text_capture: reference model plus directed scenarios.
`default_nettype none

module tb_uk101_text_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture_en;
  logic        capture_clear;
  logic [7:0]  tx_data;
  logic        tx_strobe;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [13:0] capture_len;
  logic        capturing;
  logic        overflow;

  uk101_text_capture dut (
    .clk           (clk),
    .reset         (reset),
    .capture_en    (capture_en),
    .capture_clear (capture_clear),
    .tx_data       (tx_data),
    .tx_strobe     (tx_strobe),
    .ioctl_upload  (ioctl_upload),
    .ioctl_rd      (ioctl_rd),
    .ioctl_addr    (ioctl_addr),
    .ioctl_din     (ioctl_din),
    .ioctl_wait    (ioctl_wait),
    .capture_len   (capture_len),
    .capturing     (capturing),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte array holding the text, its length, and a countdown
  // for the two cycles an upload read is outstanding.
  logic [7:0] m_mem [0:8191];
  int         m_len  = 0;
  bit         m_ovf  = 1'b0;
  bit         m_capt = 1'b0;
  int         m_busy = 0;
  int         m_addr = 0;
  logic [7:0] m_din  = 8'h00;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_len = 0; m_ovf = 0; m_capt = 0; m_busy = 0; m_din = 8'h00;
      end else begin
        bit         was_capt;
        int         was_busy;
        logic [7:0] b;
        was_capt = m_capt;
        was_busy = m_busy;
        if (m_busy == 1) begin
          m_din  = (m_addr < m_len) ? m_mem[m_addr] : 8'h00;
          m_busy = 0;
          m_capt = capture_en && !ioctl_upload;
        end else if (m_busy == 2) begin
          m_busy = 1;
        end else if (ioctl_rd && ioctl_upload) begin
          m_busy = 2;
          m_addr = int'(ioctl_addr);
        end else if (!m_capt && capture_en && !ioctl_upload) begin
          m_capt = 1;
        end else if (m_capt && !capture_en) begin
          m_capt = 0;
        end
        b = tx_data & 8'h7F;
        if (capture_clear) begin
          m_len = 0;
          m_ovf = 0;
        end else if (was_capt && was_busy == 0 && !ioctl_upload && tx_strobe && b != 8'h00) begin
          if (m_len < 8192) begin
            m_mem[m_len] = b;
            m_len++;
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("len",       32'(capture_len), 32'(m_len));
        chk("overflow",  32'(overflow),    32'(m_ovf));
        chk("capturing", 32'(capturing),   32'(m_capt && m_busy == 0));
        chk("wait",      32'(ioctl_wait),  32'(m_busy != 0));
        chk("din",       32'(ioctl_din),   32'(m_din));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    tx_data   = d;
    tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
  endtask

  task automatic hps_read(input logic [15:0] a, output logic [7:0] d, output int wait_cycles);
    int n;
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
    n = 0;
    while (ioctl_wait && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) chk("read_timeout", 32'(n), 32'd2);
    d           = ioctl_din;
    wait_cycles = n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         wc;
    reset = 1'b1;
    capture_en = 0; capture_clear = 0; tx_data = 0; tx_strobe = 0;
    ioctl_upload = 0; ioctl_rd = 0; ioctl_addr = 0;
    repeat (3) tick();
    reset = 1'b0;
    cmp_on = 1'b1;
    chk("rst_len", 32'(capture_len), 32'd0);
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_capturing", 32'(capturing), 32'd0);

    // 1: masking, NUL drop, readback, read past the end
    capture_en = 1'b1;
    tick();
    strobe(8'h48); strobe(8'hC5); strobe(8'h00); strobe(8'h4C);
    chk("t1_len", 32'(capture_len), 32'd3);
    ioctl_upload = 1'b1;
    tick();
    hps_read(16'd0, d, wc); chk("t1_rd0", 32'(d), 32'h48);
    hps_read(16'd1, d, wc); chk("t1_rd1", 32'(d), 32'h45);
    hps_read(16'd2, d, wc); chk("t1_rd2", 32'(d), 32'h4C);
    hps_read(16'd3, d, wc); chk("t1_rd3", 32'(d), 32'h00);

    // 2: fill to capacity, then one more byte overflows
    ioctl_upload = 1'b0;
    tick();
    capture_clear = 1'b1; tick(); capture_clear = 1'b0;
    tx_data = 8'h41; tx_strobe = 1'b1;
    repeat (8192) tick();
    tx_data = 8'h42;
    tick();
    tx_strobe = 1'b0;
    chk("t2_len", 32'(capture_len), 32'd8192);
    chk("t2_ovf", 32'(overflow), 32'd1);
    ioctl_upload = 1'b1;
    tick();
    hps_read(16'd8191, d, wc); chk("t2_rd_last", 32'(d), 32'h41);
    hps_read(16'd8192, d, wc); chk("t2_rd_beyond", 32'(d), 32'h00);
    hps_read(16'hFFFF, d, wc); chk("t2_rd_ffff", 32'(d), 32'h00);

    // 3: handshake timing and frozen buffer during upload
    hps_read(16'd1, d, wc);
    chk("t3_wait_cycles", 32'(wc), 32'd2);
    chk("t3_rd1", 32'(d), 32'h41);
    strobe(8'h55);
    chk("t3_len_frozen", 32'(capture_len), 32'd8192);

    // 4: clear beats a coincident store; next byte lands at address 0
    ioctl_upload = 1'b0;
    tick();
    tx_data = 8'h41; tx_strobe = 1'b1; capture_clear = 1'b1;
    tick();
    tx_strobe = 1'b0; capture_clear = 1'b0;
    chk("t4_len", 32'(capture_len), 32'd0);
    chk("t4_ovf", 32'(overflow), 32'd0);
    strobe(8'h31);
    chk("t4_len1", 32'(capture_len), 32'd1);
    ioctl_upload = 1'b1;
    tick();
    hps_read(16'd0, d, wc); chk("t4_rd0", 32'(d), 32'h31);
    capture_clear = 1'b1; tick(); capture_clear = 1'b0;
    hps_read(16'd0, d, wc); chk("t4_rd_cleared", 32'(d), 32'h00);

    // 5: capture disabled ignores strobes
    ioctl_upload = 1'b0;
    capture_en   = 1'b0;
    tick();
    strobe(8'h41);
    chk("t5_len0", 32'(capture_len), 32'd0);
    chk("t5_capturing", 32'(capturing), 32'd0);
    capture_en = 1'b1;
    tick();
    strobe(8'h41);
    chk("t5_len1", 32'(capture_len), 32'd1);

    // 6: asynchronous reset in the middle of a read
    ioctl_upload = 1'b1;
    ioctl_addr   = 16'd0;
    ioctl_rd     = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    chk("t6_wait_hi", 32'(ioctl_wait), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_wait_async", 32'(ioctl_wait), 32'd0);
    chk("t6_len", 32'(capture_len), 32'd0);
    chk("t6_din", 32'(ioctl_din), 32'h00);
    chk("t6_capturing", 32'(capturing), 32'd0);
    tick();
    reset = 1'b0;
    ioctl_upload = 1'b0;
    repeat (3) tick();

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
